// File: rtl/tilelink_ram_arbiter_pkg.sv
// tilelink_ram_arbiter_pkg
// Shared TileLink-UL channel types and opcode constants for the RAM arbiter.
// tilelink_a : A-channel request bundle (valid, opcode, param, size, source,
//              address, mask, data).
// tilelink_d : D-channel response bundle (valid, opcode, param, size, source,
//              sink, error, data).
package tilelink_ram_arbiter_pkg;

    localparam int TL_ADDR_W   = 32;
    localparam int TL_DATA_W   = 32;
    localparam int TL_MASK_W   = 4;
    localparam int TL_SIZE_W   = 2;
    localparam int TL_SOURCE_W = 4;
    localparam int TL_SINK_W   = 1;

    // A-channel opcodes
    localparam logic [2:0] TL_GET         = 3'd4;
    localparam logic [2:0] TL_PUT_FULL    = 3'd0;
    localparam logic [2:0] TL_PUT_PARTIAL = 3'd1;
    // D-channel opcodes
    localparam logic [2:0] TL_ACK         = 3'd0;
    localparam logic [2:0] TL_ACK_DATA    = 3'd1;

    typedef struct packed {
        logic                   a_valid;
        logic [2:0]             a_opcode;
        logic [2:0]             a_param;
        logic [TL_SIZE_W-1:0]   a_size;
        logic [TL_SOURCE_W-1:0] a_source;
        logic [TL_ADDR_W-1:0]   a_address;
        logic [TL_MASK_W-1:0]   a_mask;
        logic [TL_DATA_W-1:0]   a_data;
    } tilelink_a;

    typedef struct packed {
        logic                   d_valid;
        logic [2:0]             d_opcode;
        logic [1:0]             d_param;
        logic [TL_SIZE_W-1:0]   d_size;
        logic [TL_SOURCE_W-1:0] d_source;
        logic [TL_SINK_W-1:0]   d_sink;
        logic                   d_error;
        logic [TL_DATA_W-1:0]   d_data;
    } tilelink_d;

    // Only Get and the two Put flavours map onto the RAM; anything else misses.
    function automatic logic tl_opcode_legal(input logic [2:0] op);
        return (op == TL_GET) || (op == TL_PUT_FULL) || (op == TL_PUT_PARTIAL);
    endfunction

endpackage

// File: rtl/tilelink_ram_arbiter.sv
// tilelink_ram_arbiter
// Shares one single-ported block RAM between two TileLink-UL masters
// (port 0 = instruction fetch, port 1 = data). One transaction is in flight
// at a time; contention is resolved round-robin.
//
// Ports:
//   clock, reset            sole clock (rising edge), synchronous active-high reset
//   p0_tla / p0_a_ready     port 0 A-channel request / accept strobe
//   p0_tld / p0_d_ready     port 0 D-channel response / consume strobe
//   p1_*                    same for port 1
//   ram_tla, ram_cs,        request, chip select and write enable to the RAM,
//   ram_wren                combinational from IDLE and the arbitration result
//   ram_rdata               RAM registered read data, valid the cycle after ram_cs
module tilelink_ram_arbiter
    import tilelink_ram_arbiter_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
    parameter logic [31:0] ADDR_MASK = 32'hFFFF_F000
) (
    input  logic        clock,
    input  logic        reset,
    input  tilelink_a   p0_tla,
    output logic        p0_a_ready,
    output tilelink_d   p0_tld,
    input  logic        p0_d_ready,
    input  tilelink_a   p1_tla,
    output logic        p1_a_ready,
    output tilelink_d   p1_tld,
    input  logic        p1_d_ready,
    output tilelink_a   ram_tla,
    output logic        ram_cs,
    output logic        ram_wren,
    input  logic [31:0] ram_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_HOLD
    } state_t;

    state_t                 state_q,      state_d;
    logic                   last_grant_q, last_grant_d;
    logic                   port_q,       port_d;
    logic [TL_SOURCE_W-1:0] source_q,     source_d;
    logic [TL_SIZE_W-1:0]   size_q,       size_d;
    logic                   is_get_q,     is_get_d;
    logic                   miss_q,       miss_d;
    logic [31:0]            resp_data_q,  resp_data_d;

    logic                   grant1;
    logic                   win_hit;
    logic                   d_ready_w;
    logic [31:0]            rd_data;
    tilelink_a              win;
    tilelink_d              rsp;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        port_d       = port_q;
        source_d     = source_q;
        size_d       = size_q;
        is_get_d     = is_get_q;
        miss_d       = miss_q;
        resp_data_d  = resp_data_q;

        p0_a_ready   = 1'b0;
        p1_a_ready   = 1'b0;
        p0_tld       = '0;
        p1_tld       = '0;
        ram_tla      = '0;
        ram_cs       = 1'b0;
        ram_wren     = 1'b0;
        rsp          = '0;

        // Port 1 wins when it is the only requester, or when both request
        // and port 0 was granted last.
        grant1    = p1_tla.a_valid && (!p0_tla.a_valid || !last_grant_q);
        win       = grant1 ? p1_tla : p0_tla;
        win_hit   = ((win.a_address & ADDR_MASK) == ADDR_BASE) && tl_opcode_legal(win.a_opcode);
        d_ready_w = port_q ? p1_d_ready : p0_d_ready;
        // Only a Get that hit returns RAM data; everything else answers zero.
        rd_data   = (is_get_q && !miss_q) ? ram_rdata : 32'h0;

        case (state_q)
            S_IDLE: begin
                if (!reset && (p0_tla.a_valid || p1_tla.a_valid)) begin
                    p0_a_ready   = !grant1;
                    p1_a_ready   = grant1;
                    if (win_hit) begin
                        ram_tla  = win;
                        ram_cs   = 1'b1;
                        ram_wren = (win.a_opcode != TL_GET);
                    end
                    last_grant_d = grant1;
                    port_d       = grant1;
                    source_d     = win.a_source;
                    size_d       = win.a_size;
                    is_get_d     = (win.a_opcode == TL_GET);
                    miss_d       = !win_hit;
                    state_d      = S_DATA;
                end
            end
            S_DATA: begin
                rsp.d_data  = rd_data;
                // RAM output returns to zero once cs drops, so keep a copy
                // for a back-pressured response.
                resp_data_d = rd_data;
                state_d     = d_ready_w ? S_IDLE : S_HOLD;
            end
            S_HOLD: begin
                rsp.d_data = resp_data_q;
                if (d_ready_w) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_q != S_IDLE) begin
            rsp.d_valid  = 1'b1;
            rsp.d_opcode = is_get_q ? TL_ACK_DATA : TL_ACK;
            rsp.d_source = source_q;
            rsp.d_size   = size_q;
            rsp.d_error  = miss_q;
        end

        // The losing port always sees an all-zero D channel.
        if (!reset) begin
            if (port_q) begin
                p1_tld = rsp;
            end else begin
                p0_tld = rsp;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            port_q       <= 1'b0;
            source_q     <= '0;
            size_q       <= '0;
            is_get_q     <= 1'b0;
            miss_q       <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            port_q       <= port_d;
            source_q     <= source_d;
            size_q       <= size_d;
            is_get_q     <= is_get_d;
            miss_q       <= miss_d;
            resp_data_q  <= resp_data_d;
        end
    end

endmodule
